// File: rtl/riscv_instr_loader_if.sv
// Loader bus: extract-stage inputs on one side, instruction memory and core control on the other.
interface riscv_instr_loader_if #(
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned DATA_BITS = 32
);
    // Extract-stage side
    logic [DATA_BITS-1:0] instr_packet;
    logic                 instr_wr_en;
    logic                 ap_start_user;
    logic                 ap_start_pulse_user;

    // Instruction-memory write port
    logic                 imem_we;
    logic [ADDR_BITS-1:0] imem_addr;
    logic [DATA_BITS-1:0] imem_wdata;

    // Core control and status
    logic                 core_reset;
    logic                 load_done;
    logic [DATA_BITS-1:0] checksum;
    logic [2:0]           err_flags;

    // Driven by the extract stage
    modport master (
        output instr_packet,
        output instr_wr_en,
        output ap_start_user,
        output ap_start_pulse_user,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata,
        input  core_reset,
        input  load_done,
        input  checksum,
        input  err_flags
    );

    // Implemented by the loader
    modport slave (
        input  instr_packet,
        input  instr_wr_en,
        input  ap_start_user,
        input  ap_start_pulse_user,
        output imem_we,
        output imem_addr,
        output imem_wdata,
        output core_reset,
        output load_done,
        output checksum,
        output err_flags
    );
endinterface

// File: rtl/riscv_instr_loader.sv
// Instruction loader: takes a length header followed by program words, writes them into
// instruction memory, then holds the RISC-V core in reset until a start pulse releases it.
module riscv_instr_loader #(
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned DATA_BITS = 32
) (
    input  logic                clk,
    input  logic                reset,
    riscv_instr_loader_if.slave bus
);

    localparam int unsigned CNT_BITS = ADDR_BITS + 1;
    localparam logic [CNT_BITS-1:0] DEPTH = {1'b1, {ADDR_BITS{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_READY = 2'd2,
        S_RUN   = 2'd3
    } state_e;

    state_e               state_q, state_d;

    logic [CNT_BITS-1:0]  len_q, len_d;
    logic [CNT_BITS-1:0]  idx_q, idx_d;
    logic                 we_q, we_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
    logic                 core_reset_q, core_reset_d;
    logic                 load_done_q, load_done_d;
    logic [DATA_BITS-1:0] checksum_q, checksum_d;
    logic [2:0]           err_q, err_d;

    logic [CNT_BITS-1:0]  hdr_len;
    logic [CNT_BITS-1:0]  idx_inc;
    logic                 hdr_ok;
    logic                 hdr_too_long;

    // Header decode and index increment shared by both combinational processes
    always_comb begin
        hdr_len      = bus.instr_packet[ADDR_BITS:0];
        idx_inc      = idx_q + CNT_BITS'(1);
        hdr_ok       = (hdr_len != '0) && (hdr_len <= DEPTH);
        hdr_too_long = (hdr_len > DEPTH);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.instr_wr_en) begin
                    if (hdr_len == '0) begin
                        state_d = S_READY;
                    end else if (hdr_ok) begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (bus.instr_wr_en && (idx_inc == len_q)) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (bus.ap_start_pulse_user) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!bus.ap_start_user) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        len_d      = len_q;
        idx_d      = idx_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        checksum_d = checksum_q;
        err_d      = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.instr_wr_en) begin
                    if (hdr_ok) begin
                        len_d      = hdr_len;
                        idx_d      = '0;
                        checksum_d = '0;
                    end
                    if (hdr_too_long) begin
                        err_d[0] = 1'b1;
                    end
                end
                if (bus.ap_start_pulse_user) begin
                    err_d[1] = 1'b1;
                end
            end
            S_LOAD: begin
                if (bus.instr_wr_en) begin
                    we_d       = 1'b1;
                    addr_d     = idx_q[ADDR_BITS-1:0];
                    wdata_d    = bus.instr_packet;
                    idx_d      = idx_inc;
                    checksum_d = checksum_q ^ bus.instr_packet;
                end
                if (bus.ap_start_pulse_user) begin
                    err_d[1] = 1'b1;
                end
            end
            S_READY: begin
                if (bus.instr_wr_en) begin
                    err_d[2] = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.instr_wr_en) begin
                    err_d[2] = 1'b1;
                end
                if (!bus.ap_start_user) begin
                    idx_d      = '0;
                    checksum_d = '0;
                end
            end
            default: ;
        endcase

        core_reset_d = (state_d != S_RUN);
        load_done_d  = (state_d == S_READY) || (state_d == S_RUN);
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q        <= '0;
            idx_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_reset_q <= 1'b1;
            load_done_q  <= 1'b0;
            checksum_q   <= '0;
            err_q        <= '0;
        end else begin
            len_q        <= len_d;
            idx_q        <= idx_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            core_reset_q <= core_reset_d;
            load_done_q  <= load_done_d;
            checksum_q   <= checksum_d;
            err_q        <= err_d;
        end
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.core_reset = core_reset_q;
    assign bus.load_done  = load_done_q;
    assign bus.checksum   = checksum_q;
    assign bus.err_flags  = err_q;

endmodule

// File: tb/tb_riscv_instr_loader.sv
// Self-checking bench for riscv_instr_loader: directed vectors, a behavioural reference
// model compared every cycle, and literal checks at key points.
module tb_riscv_instr_loader;

    localparam int unsigned A     = 2;
    localparam int unsigned D     = 32;
    localparam int          DEPTH = 1 << A;

    logic clk;
    logic reset;

    riscv_instr_loader_if #(.ADDR_BITS(A), .DATA_BITS(D)) bus ();

    riscv_instr_loader #(.ADDR_BITS(A), .DATA_BITS(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: phase 0 idle, 1 loading, 2 loaded, 3 running
    int         ph     = 0;
    int         left   = 0;
    int         cnt    = 0;
    bit         m_ok   = 1'b0;
    logic       m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic       m_crst;
    logic       m_done;
    logic [31:0] m_cs;
    logic [2:0] m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs held across that edge
    task automatic model_step();
        int n;
        if (reset) begin
            ph = 0; left = 0; cnt = 0;
            m_we = 0; m_addr = 0; m_wdata = 0; m_cs = 0; m_err = 0;
            m_ok = 1'b1;
        end else begin
            m_we = 0;
            if (ph == 0) begin
                if (bus.instr_wr_en) begin
                    n = int'(bus.instr_packet % (32'd1 << (A + 1)));
                    if (n == 0) ph = 2;
                    else if (n <= DEPTH) begin
                        left = n; cnt = 0; m_cs = 0; ph = 1;
                    end else m_err[0] = 1'b1;
                end
                if (bus.ap_start_pulse_user) m_err[1] = 1'b1;
            end else if (ph == 1) begin
                if (bus.instr_wr_en) begin
                    m_we    = 1;
                    m_addr  = 32'(cnt % DEPTH);
                    m_wdata = bus.instr_packet;
                    m_cs    = m_cs ^ bus.instr_packet;
                    cnt++;
                    left--;
                    if (left == 0) ph = 2;
                end
                if (bus.ap_start_pulse_user) m_err[1] = 1'b1;
            end else if (ph == 2) begin
                if (bus.instr_wr_en) m_err[2] = 1'b1;
                if (bus.ap_start_pulse_user) ph = 3;
            end else begin
                if (bus.instr_wr_en) m_err[2] = 1'b1;
                if (!bus.ap_start_user) begin
                    ph = 0; cnt = 0; m_cs = 0;
                end
            end
        end
        m_crst = (ph != 3);
        m_done = (ph == 2) || (ph == 3);
    endtask

    // One cycle of stimulus; returns 1 time unit after the edge with the model updated
    task automatic cyc(input logic we, input logic [31:0] pkt, input logic st,
                       input logic pl, input logic rs);
        bus.instr_wr_en         = we;
        bus.instr_packet        = pkt;
        bus.ap_start_user       = st;
        bus.ap_start_pulse_user = pl;
        reset                   = rs;
        @(posedge clk);
        #1;
        model_step();
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_ok) begin
            chk("imem_we",    32'(bus.imem_we),    32'(m_we));
            chk("imem_addr",  32'(bus.imem_addr),  m_addr);
            chk("imem_wdata", bus.imem_wdata,      m_wdata);
            chk("core_reset", 32'(bus.core_reset), 32'(m_crst));
            chk("load_done",  32'(bus.load_done),  32'(m_done));
            chk("checksum",   bus.checksum,        m_cs);
            chk("err_flags",  32'(bus.err_flags),  32'(m_err));
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_we"},   32'(bus.imem_we),    32'd0);
        chk({tag, "_addr"}, 32'(bus.imem_addr),  32'd0);
        chk({tag, "_wd"},   bus.imem_wdata,      32'd0);
        chk({tag, "_crst"}, 32'(bus.core_reset), 32'd1);
        chk({tag, "_done"}, 32'(bus.load_done),  32'd0);
        chk({tag, "_cs"},   bus.checksum,        32'd0);
        chk({tag, "_err"},  32'(bus.err_flags),  32'd0);
    endtask

    initial begin
        bus.instr_wr_en = 0; bus.instr_packet = 0;
        bus.ap_start_user = 0; bus.ap_start_pulse_user = 0;
        reset = 1;

        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk_reset_vals("rst0");

        // Header 3 and three back-to-back words
        cyc(1, 32'd3, 0, 0, 0);
        chk("h3_we", 32'(bus.imem_we), 32'd0);
        cyc(1, 32'h11, 0, 0, 0);
        chk("w0_we", 32'(bus.imem_we), 32'd1);
        chk("w0_addr", 32'(bus.imem_addr), 32'd0);
        chk("w0_wd", bus.imem_wdata, 32'h11);
        cyc(1, 32'h22, 0, 0, 0);
        chk("w1_addr", 32'(bus.imem_addr), 32'd1);
        cyc(1, 32'h33, 0, 0, 0);
        chk("w2_addr", 32'(bus.imem_addr), 32'd2);
        chk("w2_done", 32'(bus.load_done), 32'd1);
        chk("w2_cs", bus.checksum, 32'h0);
        cyc(0, 0, 0, 0, 0);
        chk("hold_we", 32'(bus.imem_we), 32'd0);
        chk("hold_addr", 32'(bus.imem_addr), 32'd2);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0);

        // Two-word load, start, then stop
        cyc(1, 32'd2, 0, 0, 0);
        cyc(1, 32'hA5A5_0000, 0, 0, 0);
        cyc(1, 32'h0000_5A5A, 0, 0, 0);
        chk("l2_cs", bus.checksum, 32'hA5A5_5A5A);
        chk("l2_done", 32'(bus.load_done), 32'd1);
        cyc(0, 0, 1, 0, 0);
        chk("lvl_only_crst", 32'(bus.core_reset), 32'd1);
        cyc(0, 0, 1, 1, 0);
        chk("run_crst", 32'(bus.core_reset), 32'd0);
        cyc(0, 0, 1, 0, 0);
        chk("run_hold_crst", 32'(bus.core_reset), 32'd0);
        cyc(0, 0, 0, 0, 0);
        chk("stop_crst", 32'(bus.core_reset), 32'd1);
        chk("stop_done", 32'(bus.load_done), 32'd0);
        chk("stop_cs", bus.checksum, 32'h0);

        // Oversized header, then a full-depth load
        cyc(0, 0, 0, 0, 1);
        cyc(1, 32'd5, 0, 0, 0);
        chk("len_err", 32'(bus.err_flags), 32'd1);
        chk("len_we", 32'(bus.imem_we), 32'd0);
        cyc(1, 32'd4, 0, 0, 0);
        cyc(1, 32'h1000_0001, 0, 0, 0);
        cyc(1, 32'h0200_0020, 0, 0, 0);
        cyc(1, 32'h0030_0300, 0, 0, 0);
        chk("full_done_early", 32'(bus.load_done), 32'd0);
        cyc(1, 32'h0004_4000, 0, 0, 0);
        chk("full_addr3", 32'(bus.imem_addr), 32'd3);
        chk("full_done", 32'(bus.load_done), 32'd1);
        chk("full_cs", bus.checksum, 32'h1234_4321);
        cyc(0, 0, 0, 0, 0);
        chk("full_nowrap", 32'(bus.imem_we), 32'd0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0);

        // Start pulse during a load, including on the final word
        cyc(1, 32'd3, 1, 0, 0);
        cyc(1, 32'hAAAA_0001, 1, 0, 0);
        cyc(0, 0, 1, 1, 0);
        chk("early_err", 32'(bus.err_flags), 32'b011);
        chk("early_crst", 32'(bus.core_reset), 32'd1);
        cyc(1, 32'hAAAA_0002, 1, 0, 0);
        chk("early_addr1", 32'(bus.imem_addr), 32'd1);
        cyc(1, 32'hAAAA_0003, 1, 1, 0);
        chk("last_pulse_addr", 32'(bus.imem_addr), 32'd2);
        chk("last_pulse_done", 32'(bus.load_done), 32'd1);
        chk("last_pulse_crst", 32'(bus.core_reset), 32'd1);
        cyc(0, 0, 1, 0, 0);

        // Word in RUN is dropped
        cyc(0, 0, 1, 1, 0);
        cyc(1, 32'hDEAD_BEEF, 1, 0, 0);
        chk("drop_we", 32'(bus.imem_we), 32'd0);
        chk("drop_err", 32'(bus.err_flags), 32'b111);
        chk("drop_crst", 32'(bus.core_reset), 32'd0);
        cyc(0, 0, 0, 0, 0);

        // Header length taken only from the low ADDR_BITS+1 bits: zero-length
        cyc(1, 32'hFFFF_FFF8, 0, 0, 0);
        chk("zero_done", 32'(bus.load_done), 32'd1);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0);

        // Reset mid-load, coinciding with a word and a pulse
        cyc(1, 32'd4, 0, 0, 0);
        cyc(1, 32'h0000_0001, 0, 0, 0);
        cyc(1, 32'h0000_0002, 0, 0, 0);
        cyc(1, 32'h0000_0003, 1, 1, 1);
        chk_reset_vals("rst_mid");
        cyc(1, 32'h0000_0002, 0, 0, 0);
        chk("new_hdr_we", 32'(bus.imem_we), 32'd0);
        cyc(1, 32'hCAFE_0000, 0, 0, 0);
        chk("new_w0_addr", 32'(bus.imem_addr), 32'd0);
        chk("new_w0_wd", bus.imem_wdata, 32'hCAFE_0000);
        cyc(1, 32'h0000_BABE, 0, 0, 0);
        chk("new_cs", bus.checksum, 32'hCAFE_BABE);
        chk("new_done", 32'(bus.load_done), 32'd1);

        // Reset while running
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 0, 1);
        chk_reset_vals("rst_run");
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_instr_loader.md
RISCV_INSTR_LOADER -- requirements
Module: riscv_instr_loader

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10, instruction-memory word-address width (depth 2**ADDR_BITS words).
REQ-002 SHALL have parameter DATA_BITS, default 32, instruction word width.
REQ-003 SHALL have port clk  input  1  the single clock; every register is updated on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous reset, active-high.
REQ-005 SHALL have port instr_packet  input  DATA_BITS  instruction/header word from the leaf extract stage.
REQ-006 SHALL have port instr_wr_en  input  1  instr_packet valid this cycle; no back-pressure exists, so every asserted cycle is consumed.
REQ-007 SHALL have port ap_start_user  input  1  start level from the extract stage (set/clear packets).
REQ-008 SHALL have port ap_start_pulse_user  input  1  one-cycle start pulse from the extract stage.
REQ-009 SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-010 SHALL have port imem_addr  output  ADDR_BITS  instruction-memory write address.
REQ-011 SHALL have port imem_wdata  output  DATA_BITS  instruction-memory write data.
REQ-012 SHALL have port core_reset  output  1  RISC-V core reset: high except in RUN.
REQ-013 SHALL have port load_done  output  1  program fully loaded (READY or RUN).
REQ-014 SHALL have port checksum  output  DATA_BITS  running XOR of the data words of the current load.
REQ-015 SHALL have port err_flags  output  3  sticky errors: [0] length error, [1] early start, [2] word dropped.

Function
REQ-016 SHALL implement the states IDLE, LOAD, READY and RUN.
REQ-017 IDLE: instr_wr_en SHALL treat instr_packet as a header; N = instr_packet[ADDR_BITS:0].
REQ-018 Header, N == 0: next state READY.
REQ-019 Header, 1 <= N <= 2**ADDR_BITS: latch N, clear the word index and checksum, next state LOAD.
REQ-020 Header, N > 2**ADDR_BITS: set err_flags[0], stay IDLE, no write.
REQ-021 LOAD: each instr_wr_en SHALL produce, one cycle later, imem_we=1, imem_addr=index and imem_wdata=instr_packet.
REQ-022 LOAD: each accepted word SHALL increment the index and XOR the word into checksum.
REQ-023 Back-to-back instr_wr_en cycles SHALL be accepted without gaps.
REQ-024 LOAD: the word that makes the index equal N SHALL move the state to READY the next cycle.
REQ-025 The index SHALL be ADDR_BITS+1 bits wide; with N = 2**ADDR_BITS, imem_addr wraps from max to 0 only in the count, and there is no extra write.
REQ-026 imem_we SHALL be low in every cycle without an accepted LOAD word; imem_addr and imem_wdata hold their last values.
REQ-027 ap_start_pulse_user in IDLE or LOAD SHALL be ignored for state purposes and set err_flags[1].
REQ-028 This also applies when the pulse coincides with the final LOAD word: the state still goes to READY.
REQ-029 READY: ap_start_pulse_user SHALL move the state to RUN; core_reset goes low the next cycle.
REQ-030 RUN: ap_start_user == 0 SHALL move the state to IDLE; core_reset goes high the next cycle; index, checksum and load_done clear.
REQ-031 READY or RUN: instr_wr_en SHALL be discarded (no imem_we) and SHALL set err_flags[2].
REQ-032 core_reset, load_done and imem_we SHALL all be registered outputs.
REQ-033 err_flags SHALL be cleared only by reset.

Reset
REQ-034 While reset is high, the block SHALL apply: state=IDLE, imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, load_done=0, checksum=0, err_flags=0, index=0.
REQ-035 Reset SHALL win over every other input in the same cycle.
REQ-036 Reset during LOAD SHALL abandon the load, and the next instr_wr_en after reset SHALL be treated as a header.

Verification
REQ-037 Header 3, then words 0x11,0x22,0x33 back-to-back -> writes addr 0/1/2 one cycle after each word; checksum=0x00000000; load_done=1.
REQ-038 Load of 2 words, then pulse -> core_reset=0 next cycle; then clear ap_start_user -> IDLE, core_reset=1, load_done=0.
REQ-039 ADDR_BITS=2, header 5 -> err_flags=3'b001, no writes; then header 4 and four words -> addrs 0..3 written, READY.
REQ-040 Pulse during LOAD (1 of 3 words loaded) -> err_flags[1]=1, core_reset stays 1, and the remaining words still load.
REQ-041 Word sent in RUN -> no imem_we, err_flags[2]=1, state stays RUN.
REQ-042 Reset asserted after the second of 4 words -> all outputs at reset values; the next word is taken as a new header.
